// File: rtl/sync_long_ctrl.sv
// rtl/sync_long_ctrl.sv - long-preamble peak-search sequencer driving an external peak finder
// Optional search watchdog enabled by defining SYNC_LONG_TIMEOUT_EN.
module sync_long_ctrl #(
    parameter int GP_COUNTER_WIDTH = 8,
    parameter int SEARCH_LEN       = 64,
    parameter int SYM_OFFSET       = 16,
    parameter int TIMEOUT          = 255
) (
    input  logic                        CLK,
    input  logic                        s_RST,
    input  logic                        short_detect,
    input  logic                        corr_strobe,
    input  logic [GP_COUNTER_WIDTH-1:0] peak_index,
    output logic                        fm_enable,
    output logic                        fm_strobe,
    output logic [GP_COUNTER_WIDTH-1:0] fm_counter,
    output logic                        sym_start,
    output logic [GP_COUNTER_WIDTH-1:0] sym_index,
    output logic                        busy,
    output logic                        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_SETTLE,
        ST_REPORT
    } state_t;

    localparam logic [GP_COUNTER_WIDTH-1:0] LAST_SAMPLE = GP_COUNTER_WIDTH'(SEARCH_LEN - 1);
    localparam logic [GP_COUNTER_WIDTH-1:0] OFFSET      = GP_COUNTER_WIDTH'(SYM_OFFSET);

    state_t state;

`ifdef SYNC_LONG_TIMEOUT_EN
    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT - 1);
    logic [15:0] idle_cnt;
    logic        timeout_q;
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Strobe is gated without a register so it stays aligned with the magnitude sample.
    assign fm_strobe = corr_strobe && (state == ST_SEARCH);
    assign fm_enable = (state != ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (s_RST) begin
            state      <= ST_IDLE;
            fm_counter <= '0;
            sym_index  <= '0;
            sym_start  <= 1'b0;
`ifdef SYNC_LONG_TIMEOUT_EN
            idle_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            sym_start <= 1'b0;
`ifdef SYNC_LONG_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
`ifdef SYNC_LONG_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    if (short_detect) begin
                        state      <= ST_SEARCH;
                        fm_counter <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (corr_strobe) begin
                        fm_counter <= fm_counter + 1'b1;
`ifdef SYNC_LONG_TIMEOUT_EN
                        idle_cnt   <= '0;
`endif
                        if (fm_counter == LAST_SAMPLE) begin
                            state <= ST_SETTLE;
                        end
                    end
`ifdef SYNC_LONG_TIMEOUT_EN
                    // A strobe in the limit cycle takes the branch above and cancels the abort.
                    else if (idle_cnt == IDLE_LIMIT) begin
                        state     <= ST_IDLE;
                        timeout_q <= 1'b1;
                        idle_cnt  <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                    end
`endif
                end
                ST_SETTLE: begin
                    // Finder's Index register catches up with the final strobe here.
                    state <= ST_REPORT;
                end
                ST_REPORT: begin
                    sym_index <= peak_index + OFFSET;
                    sym_start <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sync_long_ctrl.md
SYNC_LONG_CTRL -- requirements
Module: sync_long_ctrl

Interface
REQ-001 SHALL have parameter GP_COUNTER_WIDTH, default 8: width of the sample counter and the peak index.
REQ-002 SHALL have parameter SEARCH_LEN, default 64: number of correlation strobes in one peak-search window, 1..2^GP_COUNTER_WIDTH.
REQ-003 SHALL have parameter SYM_OFFSET, default 16: constant added to the peak index to form the symbol start index.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum idle cycles between strobes in SEARCH, 1..65535.
REQ-005 SHALL have port CLK  in  1  the single clock; all logic on posedge.
REQ-006 SHALL have port s_RST  in  1  synchronous, active-high reset.
REQ-007 SHALL have port short_detect  in  1  one-cycle pulse from short-preamble detection that starts a search.
REQ-008 SHALL have port corr_strobe  in  1  a valid correlation magnitude is present this cycle.
REQ-009 SHALL have port peak_index  in  GP_COUNTER_WIDTH  Index from the peak finder.
REQ-010 SHALL have port fm_enable  out  1  peak finder enable; low clears the finder.
REQ-011 SHALL have port fm_strobe  out  1  gated strobe to the peak finder input_strobe.
REQ-012 SHALL have port fm_counter  out  GP_COUNTER_WIDTH  sample number to the peak finder in_Counter_Val.
REQ-013 SHALL have port sym_start  out  1  one-cycle pulse; sym_index valid.
REQ-014 SHALL have port sym_index  out  GP_COUNTER_WIDTH  peak_index + SYM_OFFSET.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port timeout_err  out  1  one-cycle pulse on search abort.

Function
REQ-017 SHALL implement states IDLE, SEARCH, SETTLE, REPORT.
REQ-018 IDLE -> SEARCH on short_detect; fm_counter cleared to 0 on that transition.
REQ-019 fm_strobe SHALL be combinational: corr_strobe AND (state == SEARCH), with zero latency, keeping magnitude and strobe aligned at the finder.
REQ-020 fm_counter SHALL hold the count of strobes accepted in the current window and increment by 1 after each accepted strobe.
REQ-021 SEARCH -> SETTLE on the accepted strobe where fm_counter == SEARCH_LEN-1; that strobe is still forwarded.
REQ-022 SETTLE SHALL last exactly one cycle, covering the finder's one-cycle Index register latency; SETTLE -> REPORT.
REQ-023 In REPORT, sym_index SHALL be registered as (peak_index + SYM_OFFSET) mod 2^GP_COUNTER_WIDTH, and sym_start SHALL pulse the following cycle as the FSM enters IDLE.
REQ-024 sym_index SHALL hold its value until the next REPORT or reset.
REQ-025 fm_enable SHALL be 1 in SEARCH, SETTLE and REPORT and 0 in IDLE, so the finder is cleared between searches.
REQ-026 short_detect outside IDLE SHALL be ignored, with no restart.
REQ-027 If short_detect and corr_strobe coincide in IDLE, that strobe SHALL NOT be forwarded; the first accepted strobe is the next one in SEARCH.
REQ-028 corr_strobe in SETTLE, REPORT or IDLE SHALL be dropped.
REQ-029 Search-to-search turnaround SHALL be at least one IDLE cycle with fm_enable = 0.

Reset
REQ-030 s_RST SHALL force IDLE with fm_enable, fm_strobe, sym_start, busy and timeout_err at 0, and fm_counter, sym_index and the idle counter at 0.
REQ-031 s_RST mid-search SHALL abort with no sym_start and no timeout_err; the finder is cleared via fm_enable = 0.
REQ-032 s_RST SHALL take priority over every other input in the same cycle.

Configuration
REQ-033 Macro SYNC_LONG_TIMEOUT_EN defined: a 16-bit idle counter SHALL count SEARCH cycles without corr_strobe and reset to 0 on each strobe.
REQ-034 When the idle counter reaches TIMEOUT, the block SHALL go to IDLE, pulse timeout_err for one cycle, and produce no sym_start.
REQ-035 If a strobe arrives in the same cycle the idle counter reaches TIMEOUT, the strobe SHALL win and no timeout occurs.
REQ-036 Macro undefined: no idle counter; SEARCH waits indefinitely; timeout_err SHALL be tied to 0.

Verification
REQ-037 Defaults; short_detect, then 64 consecutive strobes with a model finder peaking at sample 20 -> fm_counter 0..63 on fm_strobe, one SETTLE cycle, sym_start pulse, sym_index = 36.
REQ-038 Peak at sample 250, SYM_OFFSET 16, GP_COUNTER_WIDTH 8 -> sym_index = 10 (wrap).
REQ-039 short_detect coincident with corr_strobe in IDLE, plus a second short_detect mid-SEARCH -> first strobe not forwarded; no restart; exactly 64 forwarded strobes.
REQ-040 With SYNC_LONG_TIMEOUT_EN, TIMEOUT = 10, and strobes stopped after 5 -> timeout_err pulse exactly 10 cycles after the last strobe, busy = 0 next cycle, no sym_start.
REQ-041 s_RST asserted at strobe 30 -> all outputs 0 the next cycle; a new short_detect restarts with fm_counter = 0.
REQ-042 Strobes gapped by 3 idle cycles, macro undefined -> completes normally; timeout_err never asserts.
